uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receive core: the receive counterpart of the existing uart_top transmit path.
- Deserialises an asynchronous 8N1 serial line into bytes using 16x oversampling from an internal baud-tick divider.
- Presents each received byte with a one-cycle done strobe and a framing-error flag.
- Sits beside the transmitter under the top-level UART wrapper and shares its clk_100MHz and reset.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported.
- Derived: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation. Default 651.

Ports:
- clk_100MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last received byte; held until the next successful byte.
- rx_done  output  1  one-cycle pulse; data_out valid in the same cycle.
- frame_err  output  1  set with rx_done when the stop bit sampled low; held until the next rx_done.
- parity_err  output  1  parity mismatch; see Optional Feature.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data_out=0, rx_done=0, frame_err=0, parity_err=0, busy=0, state=IDLE, all counters 0. Both rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Tick divider:
  - Free-running counter 0..DIV-1.
  - tick=1 for one cycle when count==DIV-1, then wraps to 0.
  - Runs in all states.
- Sample counter s (4 bit) counts ticks. Bit counter n (3 bit). Shift register sh (8 bit).
- IDLE: when rx_s==0, go to START with s=0.
- START, on tick:
  - s==7 and rx_s==0: go to DATA with s=0, n=0.
  - s==7 and rx_s==1: glitch, return to IDLE. No outputs change.
  - Otherwise s++.
- DATA, on tick:
  - s==15: sh <= {rx_s, sh[7:1]} (LSB first), s=0. If n==7 go to STOP (or PARITY, see Optional Feature), else n++.
  - Otherwise s++.
- STOP, on tick at s==15:
  - data_out<=sh, rx_done<=1 for one cycle, frame_err<=~rx_s.
  - If rx_s==1 go to IDLE, else go to BRK_WAIT.
- BRK_WAIT: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from re-triggering reception.
- data_out is updated even on a framing error; the consumer must qualify it with frame_err.
- Latency: rx_done rises about 9.5 bit periods plus 2–3 clocks after the rx falling edge. Tick jitter is up to DIV clocks.
- reset asserted mid-frame aborts immediately to the reset values. The first start edge after reset release is received normally.
- rx_done never asserts in two consecutive cycles.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1.
  - PARITY state is inserted between DATA and STOP, with the same tick/s handling.
  - At s==15, the parity bit is sampled.
  - At rx_done, parity_err <= (^sh) ^ parity_bit, i.e. 1 when even parity fails. Held until the next rx_done.
  - Latency becomes about 10.5 bit periods.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan:
All tests use CLK_FREQ=1600000, BAUD=10000, so DIV=10 and the bit period is 160 clocks.
- Idle then byte 0x55 (start, 1,0,1,0,1,0,1,0, stop=1):
  - rx_done pulses once about 1520 clocks after the start edge.
  - data_out=0x55, frame_err=0, busy high throughout the frame.
- Back-to-back bytes 0x00, 0xFF, 0xA5 with no idle gap: three rx_done pulses exactly 1600±10 clocks apart, data_out sequence 0x00, 0xFF, 0xA5.
- 40-clock low glitch on idle rx: no rx_done, busy returns to 0 within 100 clocks, state IDLE.
- Byte 0x3C with stop bit driven 0, then line held low 2000 clocks, then high:
  - rx_done with data_out=0x3C and frame_err=1.
  - No further rx_done while the line is low.
  - A following 0x81 frame is received with frame_err=0.
- reset pulsed during bit 4 of a frame:
  - All outputs 0 the cycle after reset.
  - The next full 0x12 frame is received correctly.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 1: parity_err=0.
  - 0x07 with parity bit 0: parity_err=1.
  - rx_done about 1680 clocks after the start edge.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receive core, 16x oversampled, 8N1 framing by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity
// errors on parity_err. Without it parity_err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rx_s
// START    | confirming the start bit at its centre (8 ticks)
// DATA     | sampling 8 data bits, LSB first, at each bit centre
// PARITY   | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP     | sampling the stop bit, publishing the byte
// BRK_WAIT | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic            sync1, rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      s, s_nx;
    logic [2:0]      n, n_nx;
    logic [7:0]      sh, sh_nx;
    logic [7:0]      data_nx;
    logic            done_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic            pbit, pbit_nx;
    logic            perr_q, perr_nx;
`endif

    // two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    // free-running oversample tick divider, runs in every state
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_100MHz) begin
        if (reset || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + DW'(1);
    end

    // FSM state and datapath registers
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            sh        <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit      <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            s         <= s_nx;
            n         <= n_nx;
            sh        <= sh_nx;
            data_out  <= data_nx;
            rx_done   <= done_nx;
            frame_err <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            pbit      <= pbit_nx;
            perr_q    <= perr_nx;
`endif
        end
    end

    // next-state and datapath updates; all sampling happens on tick
    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        sh_nx    = sh;
        data_nx  = data_out;
        done_nx  = 1'b0;
        ferr_nx  = frame_err;
`ifdef UART_RX_PARITY_EN
        pbit_nx  = pbit;
        perr_nx  = perr_q;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        sh_nx = {rx_s, sh[7:1]};
                        s_nx  = '0;
                        if (n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end else begin
                            n_nx = n + 3'd1;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        pbit_nx  = rx_s;
                        s_nx     = '0;
                        state_nx = STOP;
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        // byte is published even on a framing error
                        data_nx  = sh;
                        done_nx  = 1'b1;
                        ferr_nx  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_nx  = (^sh) ^ pbit;
`endif
                        state_nx = rx_s ? IDLE : BRK_WAIT;
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at DIV=10 (160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int DONE_LAT   = 1680;
`else
    localparam int FRAME_BITS = 10;
    localparam int DONE_LAT   = 1520;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_done, frame_err, parity_err, busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    int   start_cyc = 0;
    int   base = 0;
    logic [7:0] rb;

    int         done_cyc[$];
    logic [7:0] done_data[$];
    logic       done_ferr[$];
    logic       done_perr[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .rx_done(rx_done),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        n_checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic wait_clks(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // frame bits in line order: start, data LSB first, [parity], stop
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_bit, input bit chk_busy);
        logic [10:0] fb;
`ifdef UART_RX_PARITY_EN
        fb = {stop_bit, par_bit, b, 1'b0};
`else
        fb = {par_bit, stop_bit, b, 1'b0};
`endif
        start_cyc = cyc;
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = fb[i];
            wait_clks(40);
            if (chk_busy) check($sformatf("busy_bit%0d", i), busy, 1);
            wait_clks(BIT_CLKS - 40);
        end
    endtask

    // capture every rx_done strobe with its cycle and qualifiers
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done) begin
            check("done_single_cycle", prev_done, 0);
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
            done_data.push_back(data_out);
            done_ferr.push_back(frame_err);
            done_perr.push_back(parity_err);
        end
        prev_done = rx_done;
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        @(negedge clk);
        check("rst_data", data_out, 0);
        check("rst_done", rx_done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
        wait_clks(1);
        reset = 1'b0;
        wait_clks(50);

        // single 0x55 frame
        base = done_cnt;
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        wait_clks(20);
        check("t1_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t1_data", done_data[base], 8'h55);
            check("t1_ferr", done_ferr[base], 0);
            check("t1_perr", done_perr[base], 0);
            check("t1_latency", done_cyc[base] - start_cyc, DONE_LAT, 10);
        end
        check("t1_busy_after", busy, 0);

        // back-to-back 0x00, 0xFF, 0xA5
        base = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_clks(20);
        check("t2_count", done_cnt - base, 3);
        if (done_cnt >= base + 3) begin
            check("t2_data0", done_data[base], 8'h00);
            check("t2_data1", done_data[base+1], 8'hFF);
            check("t2_data2", done_data[base+2], 8'hA5);
            check("t2_ferr2", done_ferr[base+2], 0);
            check("t2_gap01", done_cyc[base+1] - done_cyc[base], FRAME_CLKS, 10);
            check("t2_gap12", done_cyc[base+2] - done_cyc[base+1], FRAME_CLKS, 10);
        end

        // 40-clock low glitch on an idle line
        wait_clks(200);
        base = done_cnt;
        rx = 1'b0;
        wait_clks(20);
        check("t3_busy_in_glitch", busy, 1);
        wait_clks(20);
        rx = 1'b1;
        wait_clks(100);
        check("t3_busy_after", busy, 0);
        check("t3_no_done", done_cnt - base, 0);

        // 0x3C with low stop bit, then 2000 clocks of break
        wait_clks(200);
        base = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clks(1000);
        check("t4_busy_break", busy, 1);
        wait_clks(1000);
        check("t4_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t4_data", done_data[base], 8'h3C);
            check("t4_ferr", done_ferr[base], 1);
        end
        rx = 1'b1;
        wait_clks(200);
        check("t4_busy_idle", busy, 0);
        base = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        wait_clks(20);
        check("t4b_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t4b_data", done_data[base], 8'h81);
            check("t4b_ferr", done_ferr[base], 0);
        end

        // reset in the middle of data bit 4
        wait_clks(200);
        rb = 8'h12;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            wait_clks(BIT_CLKS);
        end
        rx = rb[4];
        wait_clks(80);
        reset = 1'b1;
        wait_clks(1);
        @(negedge clk);
        check("t5_rst_data", data_out, 0);
        check("t5_rst_done", rx_done, 0);
        check("t5_rst_ferr", frame_err, 0);
        check("t5_rst_perr", parity_err, 0);
        check("t5_rst_busy", busy, 0);
        wait_clks(1);
        reset = 1'b0;
        rx = 1'b1;
        wait_clks(400);
        base = done_cnt;
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        wait_clks(20);
        check("t5_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t5_data", done_data[base], 8'h12);
            check("t5_ferr", done_ferr[base], 0);
        end

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 1 is good, 0 is bad
        wait_clks(200);
        base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_clks(20);
        check("t6_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t6_data", done_data[base], 8'h07);
            check("t6_perr_good", done_perr[base], 0);
            check("t6_latency", done_cyc[base] - start_cyc, 1680, 10);
        end
        base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        wait_clks(20);
        check("t6b_count", done_cnt - base, 1);
        if (done_cnt > base) begin
            check("t6b_perr_bad", done_perr[base], 1);
            check("t6b_ferr", done_ferr[base], 0);
        end
`else
        check("t6_perr_tied", parity_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
